// File: rtl/alu_cmd_sequencer.sv
// Multi-cycle sequencer that drives register-file/ALU datapath strobes for one command at a time.
// Optional build macro ALU_SEQ_CMD_COUNT_EN adds the retired_count output.
module alu_cmd_sequencer #(
   parameter int DW   = 16,
   parameter int IMMW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      cmd_op,
   input  logic [2:0]      cmd_rd,
   input  logic [2:0]      cmd_rn,
   input  logic [2:0]      cmd_rm,
   input  logic [1:0]      cmd_shift,
   input  logic [IMMW-1:0] cmd_imm,
   output logic [2:0]      readnum,
   output logic [2:0]      writenum,
   output logic            write,
   output logic            loada,
   output logic            loadb,
   output logic            loadc,
   output logic            loads,
   output logic            asel,
   output logic            bsel,
   output logic            vsel,
   output logic [1:0]      ALUop,
   output logic [1:0]      shift,
   output logic [DW-1:0]   datapath_in,
   output logic            done,
   output logic            err,
`ifdef ALU_SEQ_CMD_COUNT_EN
   output logic [15:0]     retired_count,
`endif
   output logic [2:0]      dbg_state_o
);

   // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE and cmd_* are ignored at every other edge.

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD_A    = 3'd1,
      S_LOAD_B    = 3'd2,
      S_EXEC      = 3'd3,
      S_WRITE     = 3'd4,
      S_WRITE_IMM = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   localparam logic [2:0] OP_MOV_IMM = 3'b000;
   localparam logic [2:0] OP_MOV_REG = 3'b001;
   localparam logic [2:0] OP_ADD     = 3'b010;
   localparam logic [2:0] OP_CMP     = 3'b011;
   localparam logic [2:0] OP_AND     = 3'b100;
   localparam logic [2:0] OP_MVN     = 3'b101;

   state_t            state_q, state_d;
   logic [2:0]        op_q, rd_q, rn_q, rm_q;
   logic [1:0]        sh_q;
   logic [IMMW-1:0]   imm_q;

   logic              accept;
   logic [2:0]        op_c, rd_c, rn_c, rm_c;
   logic [1:0]        sh_c;
   logic [IMMW-1:0]   imm_c;
   logic              illegal_c, hold_alu;
   logic [1:0]        alu_code;

   logic [2:0]        readnum_d, writenum_d;
   logic              write_d, loada_d, loadb_d, loadc_d, loads_d, asel_d, vsel_d;
   logic [1:0]        aluop_d, shift_d;
   logic [DW-1:0]     dp_d;
   logic              done_d, err_d;

   logic [2:0]        readnum_q, writenum_q;
   logic              write_q, loada_q, loadb_q, loadc_q, loads_q, asel_q, vsel_q;
   logic [1:0]        aluop_q, shift_q;
   logic [DW-1:0]     dp_q;
   logic              done_q, err_q;

   assign cmd_ready = (state_q == S_IDLE);
   assign accept    = cmd_valid && cmd_ready;

   // Decode uses the incoming fields only on the accept edge; outputs are still registered.
   assign op_c  = accept ? cmd_op    : op_q;
   assign rd_c  = accept ? cmd_rd    : rd_q;
   assign rn_c  = accept ? cmd_rn    : rn_q;
   assign rm_c  = accept ? cmd_rm    : rm_q;
   assign sh_c  = accept ? cmd_shift : sh_q;
   assign imm_c = accept ? cmd_imm   : imm_q;
   assign illegal_c = (op_c[2:1] == 2'b11);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_MOV_IMM:              state_d = S_WRITE_IMM;
                  OP_MOV_REG, OP_MVN:      state_d = S_LOAD_B;
                  OP_ADD, OP_CMP, OP_AND:  state_d = S_LOAD_A;
                  default:                 state_d = S_DONE;
               endcase
            end
         end
         S_LOAD_A:    state_d = S_LOAD_B;
         S_LOAD_B:    state_d = S_EXEC;
         S_EXEC:      state_d = (op_q == OP_CMP) ? S_DONE : S_WRITE;
         S_WRITE:     state_d = S_DONE;
         S_WRITE_IMM: state_d = S_DONE;
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      alu_code = 2'b00;
      case (op_c)
         OP_CMP:  alu_code = 2'b01;
         OP_AND:  alu_code = 2'b10;
         OP_MVN:  alu_code = 2'b11;
         default: alu_code = 2'b00;
      endcase
      // ALUop/shift stay valid from EXEC until the command retires.
      hold_alu   = (state_d == S_EXEC || state_d == S_WRITE || state_d == S_DONE) &&
                   !illegal_c && (op_c != OP_MOV_IMM);
      aluop_d    = hold_alu ? alu_code : 2'b00;
      shift_d    = hold_alu ? sh_c : 2'b00;
      loada_d    = (state_d == S_LOAD_A);
      loadb_d    = (state_d == S_LOAD_B);
      readnum_d  = loada_d ? rn_c : (loadb_d ? rm_c : 3'd0);
      loadc_d    = (state_d == S_EXEC);
      loads_d    = (state_d == S_EXEC) && (op_c != OP_MOV_REG);
      asel_d     = (state_d == S_EXEC) && (op_c == OP_MOV_REG);
      vsel_d     = (state_d == S_WRITE_IMM);
      write_d    = (state_d == S_WRITE) || (state_d == S_WRITE_IMM);
      writenum_d = write_d ? rd_c : 3'd0;
      dp_d       = vsel_d ? {{(DW-IMMW){imm_c[IMMW-1]}}, imm_c} : '0;
      done_d     = (state_d == S_DONE);
      err_d      = done_d && illegal_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         rd_q       <= '0;
         rn_q       <= '0;
         rm_q       <= '0;
         sh_q       <= '0;
         imm_q      <= '0;
         readnum_q  <= '0;
         writenum_q <= '0;
         write_q    <= 1'b0;
         loada_q    <= 1'b0;
         loadb_q    <= 1'b0;
         loadc_q    <= 1'b0;
         loads_q    <= 1'b0;
         asel_q     <= 1'b0;
         vsel_q     <= 1'b0;
         aluop_q    <= '0;
         shift_q    <= '0;
         dp_q       <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rn_q  <= cmd_rn;
            rm_q  <= cmd_rm;
            sh_q  <= cmd_shift;
            imm_q <= cmd_imm;
         end
         readnum_q  <= readnum_d;
         writenum_q <= writenum_d;
         write_q    <= write_d;
         loada_q    <= loada_d;
         loadb_q    <= loadb_d;
         loadc_q    <= loadc_d;
         loads_q    <= loads_d;
         asel_q     <= asel_d;
         vsel_q     <= vsel_d;
         aluop_q    <= aluop_d;
         shift_q    <= shift_d;
         dp_q       <= dp_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

`ifdef ALU_SEQ_CMD_COUNT_EN
   logic [15:0] count_q;

   // Counts on the same edge that raises done, so the two change together.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (done_d) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign retired_count = count_q;
`endif

   assign readnum     = readnum_q;
   assign writenum    = writenum_q;
   assign write       = write_q;
   assign loada       = loada_q;
   assign loadb       = loadb_q;
   assign loadc       = loadc_q;
   assign loads       = loads_q;
   assign asel        = asel_q;
   assign bsel        = 1'b0;
   assign vsel        = vsel_q;
   assign ALUop       = aluop_q;
   assign shift       = shift_q;
   assign datapath_in = dp_q;
   assign done        = done_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Multi-cycle controller that issues register-to-register ALU commands to the lab datapath (register file, A/B/C registers, shifter, ALU, status register).
- Accepts one command at a time over a valid/ready handshake, then drives the datapath strobes in a fixed state sequence.
- Pulses done when the command retires.
- It is the initiator of the ALU interface: Ain/Bin/ALUop/out/Z are driven by the datapath under this block's control.

Parameters:
- DW, 16, datapath word width; width of datapath_in.
- IMMW, 8, immediate field width; sign-extended to DW.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept
- cmd_op  in  3  000 MOV_IMM, 001 MOV_REG, 010 ADD, 011 CMP, 100 AND, 101 MVN, 110/111 illegal
- cmd_rd  in  3  destination register
- cmd_rn  in  3  first source register (A)
- cmd_rm  in  3  second source register (B, through shifter)
- cmd_shift  in  2  shifter control for Rm
- cmd_imm  in  IMMW  immediate for MOV_IMM
- readnum  out  3  register file read address
- writenum  out  3  register file write address
- write  out  1  register file write strobe
- loada  out  1  A register load
- loadb  out  1  B register load
- loadc  out  1  C register load
- loads  out  1  status (Z) register load
- asel  out  1  1 forces Ain to 0
- bsel  out  1  held 0
- vsel  out  1  1 = datapath_in to writeback, 0 = C
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B
- shift  out  2  shifter control
- datapath_in  out  DW  sign-extended cmd_imm
- done  out  1  one-cycle retire pulse
- err  out  1  one-cycle pulse with done for illegal cmd_op

Behaviour:
- Reset:
  - State goes to IDLE; all strobes are 0.
  - readnum, writenum, ALUop, shift, asel, vsel, datapath_in, done and err are 0.
  - cmd_ready is 1 on the cycle after reset deasserts.
- Handshake:
  - cmd_ready = (state==IDLE).
  - A command is accepted on the rising edge where cmd_valid && cmd_ready. All cmd_* fields are latched into an internal command register on that edge.
  - cmd_* inputs are ignored at all other times, so changing them mid-command has no effect.
- Outputs are Moore: they are decoded from the state and the latched command register only. There is no combinational path from cmd_* to any output other than cmd_ready.
- States: IDLE, LOAD_A, LOAD_B, EXEC, WRITE, WRITE_IMM, DONE.
- Sequences (N = cycles from the accept edge to done high):
  - MOV_IMM: WRITE_IMM, DONE. N=2.
  - MOV_REG: LOAD_B, EXEC(asel=1, ALUop=00), WRITE, DONE. N=4.
  - ADD: LOAD_A, LOAD_B, EXEC(ALUop=00), WRITE, DONE. N=5.
  - CMP: LOAD_A, LOAD_B, EXEC(ALUop=01), DONE. No WRITE. N=4.
  - AND: LOAD_A, LOAD_B, EXEC(ALUop=10), WRITE, DONE. N=5.
  - MVN: LOAD_B, EXEC(ALUop=11), WRITE, DONE. N=4.
  - illegal: DONE with err=1. No strobes. N=1.
- Per-state outputs:
  - LOAD_A: readnum=rn, loada=1.
  - LOAD_B: readnum=rm, loadb=1.
  - EXEC: loadc=1, shift=latched shift, bsel=0. loads=1 for ADD, CMP, AND and MVN; loads=0 for MOV_REG.
  - WRITE: writenum=rd, vsel=0, write=1.
  - WRITE_IMM: writenum=rd, vsel=1, write=1, datapath_in = sign-extend(imm).
- Holding rules:
  - Every strobe is high for exactly one cycle per command.
  - ALUop and shift hold their EXEC values through WRITE. They return to 0 in IDLE.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - cmd_ready is 0 in DONE, so back-to-back commands have a 1-cycle bubble.
- Reset asserted in any state:
  - Next state is IDLE and all strobes are 0 on the next edge.
  - A pending WRITE or loads never fires after reset is sampled.
  - No done is produced for the aborted command.
- cmd_valid held high in IDLE with reset high: not accepted.

Optional Feature:
- Macro: ALU_SEQ_CMD_COUNT_EN.
- Defined:
  - Adds output port retired_count (16 bits, reset 0).
  - Increments on every done pulse, including illegal commands.
  - Wraps from 0xFFFF to 0x0000.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then MOV_IMM rd=3, imm=8'hFB -> after 1 cycle: write=1, vsel=1, writenum=3, datapath_in=16'hFFFB; done on the following cycle; cmd_ready high again next cycle.
- ADD rd=2, rn=0, rm=1, shift=00 -> exactly five states in order:
  - LOAD_A: readnum=0, loada=1.
  - LOAD_B: readnum=1, loadb=1.
  - EXEC: ALUop=00, loadc=1, loads=1.
  - WRITE: writenum=2, write=1.
  - done at N=5.
- CMP rn=4, rm=4 -> loads=1 in EXEC; write never asserts; done at N=4. With the datapath attached, R4=8 gives Z=1.
- MVN rd=5, rm=6, shift=01 -> LOAD_A skipped; EXEC has ALUop=11, shift=01; done at N=4.
- cmd_op=3'b111 -> done=1 and err=1 on the cycle after accept; no strobe asserts.
- Reset during EXEC of ADD -> write stays 0; cmd_ready=1 on the cycle after reset deasserts. With ALU_SEQ_CMD_COUNT_EN, retired_count is unchanged after the abort.
